// File: rtl/param_sync_fifo.sv
// Synchronous single-clock FIFO with occupancy flags and overflow/underflow pulses.
// Latency: a write shows up in count and flags 1 cycle after the edge that accepts it. A standard-mode read gives data_out 1 cycle after r_en.
// Backpressure: a write is rejected while full and a read is rejected while empty. Each rejection pulses overflow or underflow for one cycle.
//
// Optional feature macro: PARAM_SYNC_FIFO_FWFT_EN
//   undefined : standard mode. data_out is registered on an accepted read and held otherwise.
//   defined   : first-word-fall-through. data_out shows the head word whenever empty=0.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset; takes priority over w_en/r_en
//   w_en/data_in write request and write data
//   r_en         read request
//   data_out     read data (see mode above)
//   full/empty   occupancy == DEPTH / occupancy == 0
//   almost_full  occupancy >= AF_LEVEL
//   almost_empty occupancy <= AE_LEVEL
//   count        occupancy 0..DEPTH
//   overflow     one-cycle pulse after a rejected write
//   underflow    one-cycle pulse after a rejected read
module param_sync_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic                     r_en,
   input  logic [DATA_W-1:0]        data_in,
   output logic [DATA_W-1:0]        data_out,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   // Each pointer carries one wrap bit above the address bits.
   // This distinguishes full from empty when the address bits are equal.
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] head;
   logic              wr_acc;
   logic              rd_acc;

   // Flags and count are derived only from registered pointers.
   // This keeps w_en and r_en out of every output path.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                         (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count        = wr_ptr_q - rd_ptr_q;
   assign almost_full  = (count >= PW'(AF_LEVEL));
   assign almost_empty = (count <= PW'(AE_LEVEL));
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Acceptance looks only at the pre-edge flags.
   // When full, a read is still taken. When empty, a write is still taken.
   assign wr_acc = w_en && !full;
   assign rd_acc = r_en && !empty;
   assign head   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = w_en && full;
      underflow_d = r_en && empty;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is never cleared. Resetting the pointers is enough to discard its contents.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wr_ptr_q[AW-1:0]] <= data_in;
      end
   end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
   // The head word is read straight from storage.
   // It is visible in the cycle after it is written, together with empty dropping.
   // The output is forced to zero while empty, so reset leaves it at zero.
   assign data_out = empty ? '0 : head;
`else
   logic [DATA_W-1:0] data_out_q, data_out_d;

   always_comb begin
      data_out_d = data_out_q;
      if (rd_acc) begin
         data_out_d = head;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo with DATA_W=8 and DEPTH=16.
// Directed stimulus drives a queue model of the FIFO, and status outputs are compared each cycle.
// A separate monitor checks read data whenever the FIFO presents a word.
module tb_param_sync_fifo;

   localparam int DW = 8;
   localparam int DP = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          w_en = 1'b0;
   logic          r_en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          full, empty, almost_full, almost_empty;
   logic [4:0]    count;
   logic          overflow, underflow;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] mq[$];     // model contents, head at index 0
   logic [DW-1:0] exp_q[$];  // expected read words, oldest first
   bit            e_ovf = 1'b0;
   bit            e_unf = 1'b0;

   always #5 clk = ~clk;

   param_sync_fifo #(
      .DATA_W(DW),
      .DEPTH(DP),
      .AF_LEVEL(DP - 2),
      .AE_LEVEL(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .w_en(w_en),
      .r_en(r_en),
      .data_in(data_in),
      .data_out(data_out),
      .full(full),
      .empty(empty),
      .almost_full(almost_full),
      .almost_empty(almost_empty),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic check_status();
      chk("count", 32'(count), mq.size());
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DP));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= DP - 2));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
      chk("overflow", 32'(overflow), 32'(e_ovf));
      chk("underflow", 32'(underflow), 32'(e_unf));
   endtask

   // Called just after a falling edge. It drives the inputs for one rising edge and updates the model.
   task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit rs);
      bit rd_ok, wr_ok;
      w_en    = w;
      r_en    = r;
      data_in = d;
      rst     = rs;
      if (rs) begin
         mq.delete();
         e_ovf = 1'b0;
         e_unf = 1'b0;
      end else begin
         e_ovf = w && (mq.size() == DP);
         e_unf = r && (mq.size() == 0);
         rd_ok = r && (mq.size() > 0);
         wr_ok = w && (mq.size() < DP);
         if (rd_ok) begin
`ifndef PARAM_SYNC_FIFO_FWFT_EN
            exp_q.push_back(mq[0]);
`endif
            void'(mq.pop_front());
         end
         if (wr_ok) begin
            mq.push_back(d);
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_status();
      if (rs) begin
         chk("rst_data_out", 32'(data_out), 32'h0);
      end
   endtask

   // Monitor: it samples at the rising edge and compares 3 time units later.
   // This is well before the stimulus changes at the falling edge.
   initial begin : monitor
      bit acc;
      forever begin
         @(posedge clk);
         acc = !rst && r_en && !empty;
         #3;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
         if (!empty) begin
            if (mq.size() == 0) begin
               chk("fwft_head_unexpected", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
               chk("fwft_head", 32'(data_out), 32'(mq[0]));
            end
         end
`else
         if (acc) begin
            if (exp_q.size() == 0) begin
               chk("rd_data_unexpected", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
               chk("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
         end
`endif
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      @(negedge clk);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 1);

      // Fill to full, then try one write too many.
      for (int i = 0; i < 16; i++) step(1, 0, 8'(i), 0);
      step(1, 0, 8'hFF, 0);
      step(0, 0, 8'h00, 0);

      // Drain in order, then try one read too many.
      for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
      step(0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // Hold at count 5 with simultaneous traffic so the pointers wrap.
      for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h20 + i), 0);
      for (int i = 0; i < 40; i++) step(1, 1, 8'(8'h40 + i), 0);
      for (int i = 0; i < 5; i++) step(0, 1, 8'h00, 0);

      // Full with both requests: the read is taken and the write is rejected.
      for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h80 + i), 0);
      step(1, 1, 8'hEE, 0);
      for (int i = 0; i < 15; i++) step(0, 1, 8'h00, 0);

      // Empty with both requests: the write is taken and the read is rejected.
      step(1, 1, 8'hA5, 0);
      step(0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0);

      // Reset at count 9, then confirm normal operation resumes.
      for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h50 + i), 0);
      step(0, 0, 8'h00, 1);
      step(1, 0, 8'h3C, 0);
      step(0, 1, 8'h00, 0);
      step(0, 0, 8'h00, 0);

`ifdef PARAM_SYNC_FIFO_FWFT_EN
      // A word written into an empty FIFO falls through without any read.
      step(1, 0, 8'h11, 0);
      chk("fwft_fallthrough", 32'(data_out), 32'h11);
      step(0, 1, 8'h00, 0);
`endif

      step(0, 0, 8'h00, 0);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of 2, >=4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 2, occupancy at or below which almost_empty asserts (1..DEPTH-1).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-007 SHALL have port w_en  input  1  write request.
REQ-008 SHALL have port r_en  input  1  read request.
REQ-009 SHALL have port data_in  input  DATA_W  write data, sampled with w_en.
REQ-010 SHALL have port data_out  output  DATA_W  read data.
REQ-011 SHALL have port full  output  1  occupancy == DEPTH.
REQ-012 SHALL have port empty  output  1  occupancy == 0.
REQ-013 SHALL have port almost_full  output  1  occupancy >= AF_LEVEL.
REQ-014 SHALL have port almost_empty  output  1  occupancy <= AE_LEVEL.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  one-cycle pulse: write rejected.
REQ-017 SHALL have port underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-018 SHALL accept a write at a clock edge iff w_en=1 and full=0; the accepted word is stored at wr_ptr, and wr_ptr is incremented.
REQ-019 SHALL accept a read at a clock edge iff r_en=1 and empty=0; rd_ptr is incremented.
REQ-020 SHALL use read/write pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit; wrap from DEPTH-1 to 0 toggles the MSB.
REQ-021 SHALL derive full when the pointer LSBs are equal and the MSBs differ, and empty when the pointers are identical; all flags and count are registered, or derived only from registered pointers, with no combinational path from w_en/r_en.
REQ-022 SHALL make count = wr_ptr - rd_ptr (modulo 2^($clog2(DEPTH)+1)), updated in the same cycle as the pointers.
REQ-023 SHALL, on a simultaneous accepted read and write, leave count unchanged and keep both pointers advancing.
REQ-024 SHALL, when full with w_en=1 and r_en=1, accept the read, reject the write and pulse overflow; a write is never accepted into a full FIFO.
REQ-025 SHALL, when empty with w_en=1 and r_en=1, accept the write, reject the read and pulse underflow; the word becomes readable on the next cycle.
REQ-026 SHALL pulse overflow (underflow) for exactly the cycle following a rejected write (read), and SHALL leave memory and pointers unchanged by the rejected operation.
REQ-027 SHALL, in standard mode, register data_out <= mem[rd_ptr] on an accepted read, giving 1-cycle latency, and hold data_out otherwise.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0 and data_out=0; memory contents are not cleared.
REQ-029 SHALL give rst priority over w_en/r_en in the same cycle; a reset asserted mid-operation discards all stored data.

Configuration
REQ-030 SHALL, with macro PARAM_SYNC_FIFO_FWFT_EN defined, operate first-word-fall-through: data_out presents the head word whenever empty=0, without a read; an accepted read advances to the next word on the following cycle; a word written into an empty FIFO appears on data_out 1 cycle after the write, with empty deasserting in that same cycle.
REQ-031 SHALL, without PARAM_SYNC_FIFO_FWFT_EN, use the standard-mode read of REQ-027.

Verification
REQ-032 SHALL cover the following scenario: DEPTH=16; 16 writes 0x00..0x0F, no reads -> full=1, count=16, almost_full=1 from count 14; a 17th write -> overflow pulse, count stays 16.
REQ-033 SHALL cover the following scenario: from full, 16 reads -> data 0x00..0x0F in order, each 1 cycle after r_en; then empty=1; an extra read -> underflow pulse.
REQ-034 SHALL cover the following scenario: 40 cycles of continuous simultaneous w_en/r_en at count=5 -> count constant at 5, pointers wrap, data order preserved.
REQ-035 SHALL cover the following scenario: empty, w_en=r_en=1 with data 0xA5 -> underflow pulse, count=1; next-cycle read returns 0xA5.
REQ-036 SHALL cover the following scenario: rst=1 at count=9 -> next cycle count=0, empty=1, data_out=0; a subsequent write/read of 0x3C returns 0x3C.
REQ-037 SHALL cover the following scenario: with FWFT_EN, a write of 0x11 into an empty FIFO -> data_out=0x11 with empty=0 one cycle later and no r_en required.
